// File: rtl/stonyman_sensor_model_pkg.sv
// Shared imager definitions: register map, ADC framing and the test-pattern pixel generator.
package stonyman_sensor_model_pkg;

    localparam int NUM_REGS       = 8;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_DATA_BITS  = 12;

    localparam logic [2:0] REG_COLSEL = 3'd0;
    localparam logic [2:0] REG_ROWSEL = 3'd1;
    localparam logic [2:0] REG_VSW    = 3'd2;
    localparam logic [2:0] REG_HSW    = 3'd3;
    localparam logic [2:0] REG_VREF   = 3'd4;
    localparam logic [2:0] REG_CONFIG = 3'd5;
    localparam logic [2:0] REG_NBIAS  = 3'd6;
    localparam logic [2:0] REG_AOBIAS = 3'd7;

    typedef enum logic [1:0] {
        ADC_IDLE  = 2'd0,
        ADC_SHIFT = 2'd1,
        ADC_DONE  = 2'd2
    } adc_state_t;

    // Deterministic pixel so the capture path can be checked without a real sensor.
    function automatic logic [ADC_DATA_BITS-1:0] pixel_value(
        input int                       pattern,
        input logic [ADC_DATA_BITS-1:0] const_value,
        input logic [7:0]               row,
        input logic [7:0]               col
    );
        logic [ADC_DATA_BITS-1:0] sum;
        sum = {4'b0000, row} + {4'b0000, col};
        case (pattern)
            0:       return {row[5:0], col[5:0]};
            1:       return sum << 4;
            default: return const_value;
        endcase
    endfunction

endpackage

// File: rtl/stonyman_sensor_model_if.sv
// Sensor pins: pulse bus, serial ADC lines and the inphi pulse tally.
interface stonyman_sensor_model_if;
    logic       resp;
    logic       incp;
    logic       resv;
    logic       incv;
    logic       inphi;
    logic       cs_n;
    logic       sclk;
    logic       sdata;
    logic [7:0] phi_count;

    modport master (
        output resp, incp, resv, incv, inphi, cs_n, sclk,
        input  sdata, phi_count
    );

    modport slave (
        input  resp, incp, resv, incv, inphi, cs_n, sclk,
        output sdata, phi_count
    );
endinterface

// File: rtl/stonyman_sensor_model_adc_serial_tx.sv
// Serial ADC emulation: latches a pixel on cs_n fall and shifts 16 bits out MSB first on sclk falls.
module stonyman_sensor_model_adc_serial_tx
    import stonyman_sensor_model_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs_n,
    input  logic                     sclk,
    input  logic [ADC_DATA_BITS-1:0] pixel,
    output logic                     sdata,
    output logic [15:0]              sample_count,
    output logic                     protocol_error
);

    logic       cs_d1_reg, cs_d2_reg, sclk_d1_reg, sclk_d2_reg;
    logic       cs_fall, cs_rise, sclk_fall;

    adc_state_t                state_reg, state_next;
    logic [ADC_FRAME_BITS-1:0] shift_reg, shift_next;
    logic [3:0]                index_reg, index_next;
    logic [4:0]                fall_cnt_reg, fall_cnt_next;
    logic [15:0]               sample_count_reg, sample_count_next;
    logic                      protocol_error_reg, protocol_error_next;

    assign cs_fall   =  cs_d2_reg & ~cs_d1_reg;
    assign cs_rise   = ~cs_d2_reg &  cs_d1_reg;
    assign sclk_fall =  sclk_d2_reg & ~sclk_d1_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_d1_reg          <= 1'b1;
            cs_d2_reg          <= 1'b1;
            sclk_d1_reg        <= 1'b1;
            sclk_d2_reg        <= 1'b1;
            state_reg          <= ADC_IDLE;
            shift_reg          <= '0;
            index_reg          <= '0;
            fall_cnt_reg       <= '0;
            sample_count_reg   <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            cs_d1_reg          <= cs_n;
            cs_d2_reg          <= cs_d1_reg;
            sclk_d1_reg        <= sclk;
            sclk_d2_reg        <= sclk_d1_reg;
            state_reg          <= state_next;
            shift_reg          <= shift_next;
            index_reg          <= index_next;
            fall_cnt_reg       <= fall_cnt_next;
            sample_count_reg   <= sample_count_next;
            protocol_error_reg <= protocol_error_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        shift_next          = shift_reg;
        index_next          = index_reg;
        fall_cnt_next       = fall_cnt_reg;
        sample_count_next   = sample_count_reg;
        protocol_error_next = protocol_error_reg;
        sdata               = 1'b0;
        case (state_reg)
            ADC_IDLE: begin
                if (cs_fall) begin
                    state_next    = ADC_SHIFT;
                    shift_next    = {{(ADC_FRAME_BITS-ADC_DATA_BITS){1'b0}}, pixel};
                    index_next    = 4'(ADC_FRAME_BITS - 1);
                    fall_cnt_next = '0;
                end
            end
            ADC_SHIFT, ADC_DONE: begin
                if (state_reg == ADC_SHIFT) sdata = shift_reg[index_reg];
                // cs_n rising wins over a coincident sclk fall.
                if (cs_rise) begin
                    state_next = ADC_IDLE;
                    if (fall_cnt_reg == 5'(ADC_FRAME_BITS))
                        sample_count_next = sample_count_reg + 16'd1;
                    else
                        protocol_error_next = 1'b1;
                end else if (sclk_fall && fall_cnt_reg != 5'd31) begin
                    // Extra falls in DONE still count so an overlong frame is flagged.
                    fall_cnt_next = fall_cnt_reg + 5'd1;
                    if (state_reg == ADC_SHIFT) begin
                        index_next = index_reg - 4'd1;
                        if (fall_cnt_reg == 5'(ADC_FRAME_BITS - 1)) state_next = ADC_DONE;
                    end
                end
            end
            default: state_next = ADC_IDLE;
        endcase
    end

    assign sample_count   = sample_count_reg;
    assign protocol_error = protocol_error_reg;

endmodule

// File: rtl/stonyman_sensor_model.sv
// Stonyman sensor stand-in: pulse-bus register file plus serial ADC returning a test-pattern pixel.
module stonyman_sensor_model
    import stonyman_sensor_model_pkg::*;
#(
    parameter int                       PATTERN     = 0,
    parameter logic [ADC_DATA_BITS-1:0] CONST_VALUE = 12'hA5C
) (
    input  logic                          clk,
    input  logic                          reset,
    stonyman_sensor_model_if.slave        bus,
    output logic [7:0]                    rowsel,
    output logic [7:0]                    colsel,
    output logic [7:0]                    cfg_value,
    output logic [15:0]                   sample_count,
    output logic                          protocol_error
);

    localparam int P_RESP  = 0;
    localparam int P_INCP  = 1;
    localparam int P_RESV  = 2;
    localparam int P_INCV  = 3;
    localparam int P_INPHI = 4;

    logic [4:0] pulse_in, pulse_d1_reg, pulse_d2_reg, rise;
    logic [2:0] ptr_reg;
    logic [7:0] phi_count_reg;
    logic [7:0] reg_values [NUM_REGS];
    logic [ADC_DATA_BITS-1:0] pixel;

    assign pulse_in = {bus.inphi, bus.incv, bus.resv, bus.incp, bus.resp};
    assign rise     = pulse_d1_reg & ~pulse_d2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_d1_reg  <= '0;
            pulse_d2_reg  <= '0;
            ptr_reg       <= '0;
            phi_count_reg <= '0;
        end else begin
            pulse_d1_reg <= pulse_in;
            pulse_d2_reg <= pulse_d1_reg;
            if (rise[P_RESP])      ptr_reg <= '0;
            else if (rise[P_INCP]) ptr_reg <= ptr_reg + 3'd1;
            if (rise[P_INPHI])     phi_count_reg <= phi_count_reg + 8'd1;
        end
    end

    // Each register compares against the pre-update pointer, so a same-cycle
    // pointer move never redirects the value action.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] value_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    value_reg <= '0;
                end else if (ptr_reg == 3'(gi)) begin
                    if (rise[P_RESV])      value_reg <= '0;
                    else if (rise[P_INCV]) value_reg <= value_reg + 8'd1;
                end
            end
            assign reg_values[gi] = value_reg;
        end
    endgenerate

    assign rowsel        = reg_values[REG_ROWSEL];
    assign colsel        = reg_values[REG_COLSEL];
    assign cfg_value     = reg_values[REG_CONFIG];
    assign bus.phi_count = phi_count_reg;
    assign pixel         = pixel_value(PATTERN, CONST_VALUE, rowsel, colsel);

    stonyman_sensor_model_adc_serial_tx u_adc (
        .clk            (clk),
        .reset          (reset),
        .cs_n           (bus.cs_n),
        .sclk           (bus.sclk),
        .pixel          (pixel),
        .sdata          (bus.sdata),
        .sample_count   (sample_count),
        .protocol_error (protocol_error)
    );

endmodule

// File: tb/tb_stonyman_sensor_model.sv
// Directed bench for the Stonyman sensor model: pulse decode, ADC reads, errors and mid-read reset.
module tb_stonyman_sensor_model;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rowsel, colsel, cfg_value;
    logic [15:0] sample_count;
    logic        protocol_error;
    logic [15:0] word;
    int          checks = 0;
    int          errors = 0;

    localparam logic [4:0] M_RESP  = 5'b00001;
    localparam logic [4:0] M_INCP  = 5'b00010;
    localparam logic [4:0] M_RESV  = 5'b00100;
    localparam logic [4:0] M_INCV  = 5'b01000;
    localparam logic [4:0] M_INPHI = 5'b10000;

    stonyman_sensor_model_if bus ();

    stonyman_sensor_model #(.PATTERN(0), .CONST_VALUE(12'hA5C)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .rowsel         (rowsel),
        .colsel         (colsel),
        .cfg_value      (cfg_value),
        .sample_count   (sample_count),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-22s got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic pulse(input logic [4:0] mask, input int count);
        for (int i = 0; i < count; i++) begin
            {bus.inphi, bus.incv, bus.resv, bus.incp, bus.resp} = mask;
            tick(2);
            {bus.inphi, bus.incv, bus.resv, bus.incp, bus.resp} = 5'b0;
            tick(2);
        end
    endtask

    // Bits are taken during each sclk high phase, just before the fall that advances them.
    task automatic adc_start(input int nfalls, output logic [15:0] w);
        w = '0;
        bus.cs_n = 1'b0;
        tick(3);
        for (int i = 0; i < nfalls; i++) begin
            w = {w[14:0], bus.sdata};
            bus.sclk = 1'b0;
            tick(3);
            bus.sclk = 1'b1;
            tick(3);
        end
    endtask

    task automatic adc_finish();
        bus.cs_n = 1'b1;
        tick(3);
    endtask

    initial begin
        reset = 1'b1;
        {bus.inphi, bus.incv, bus.resv, bus.incp, bus.resp} = 5'b0;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b1;
        tick(3);
        check("reset_rowsel", rowsel, 0);
        check("reset_colsel", colsel, 0);
        check("reset_cfg", cfg_value, 0);
        check("reset_sample_count", sample_count, 0);
        check("reset_protocol_error", protocol_error, 0);
        check("reset_sdata", bus.sdata, 0);
        reset = 1'b0;
        tick(2);

        pulse(M_INCP, 5);
        pulse(M_INCV, 3);
        check("cfg_after_5incp_3incv", cfg_value, 3);
        check("rowsel_untouched", rowsel, 0);
        pulse(M_RESP, 1);
        pulse(M_INCP, 1);
        pulse(M_INCV, 10);
        check("rowsel_10", rowsel, 10);

        // rowsel = 2, colsel = 3 -> pixel 0x083
        pulse(M_RESV, 1);
        pulse(M_INCV, 2);
        pulse(M_RESP, 1);
        pulse(M_INCV, 3);
        check("rowsel_2", rowsel, 2);
        check("colsel_3", colsel, 3);
        adc_start(16, word);
        check("sdata_done_zero", bus.sdata, 0);
        adc_finish();
        check("read1_word", word, 16'h0083);
        check("read1_sample_count", sample_count, 1);
        check("read1_protocol_error", protocol_error, 0);

        pulse(M_RESV, 1);
        pulse(M_INCV, 255);
        check("colsel_255", colsel, 255);
        pulse(M_INCV, 1);
        check("colsel_wrap_0", colsel, 0);
        pulse(M_INCP, 8);
        pulse(M_INCV, 1);
        check("ptr_wrap_colsel_1", colsel, 1);

        pulse(M_INCP, 4);
        pulse(M_RESP | M_INCP, 1);
        pulse(M_INCV, 1);
        check("resp_over_incp_colsel", colsel, 2);
        check("resp_over_incp_rowsel", rowsel, 2);
        pulse(M_RESV | M_INCV, 1);
        check("resv_over_incv", colsel, 0);

        pulse(M_INPHI, 3);
        check("phi_count_3", bus.phi_count, 3);
        check("inphi_no_change", colsel, 0);

        pulse(M_INCV, 3);
        adc_start(10, word);
        adc_finish();
        check("short_read_error", protocol_error, 1);
        check("short_read_count", sample_count, 1);
        adc_start(16, word);
        adc_finish();
        check("read2_word", word, 16'h0083);
        check("read2_sample_count", sample_count, 2);
        check("read2_error_sticky", protocol_error, 1);

        // Reset on the 7th sclk fall of a read.
        adc_start(6, word);
        bus.sclk = 1'b0;
        tick(3);
        reset = 1'b1;
        #1;
        check("midreset_sdata", bus.sdata, 0);
        check("midreset_sample_count", sample_count, 0);
        check("midreset_error", protocol_error, 0);
        bus.sclk = 1'b1;
        bus.cs_n = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        pulse(M_INCV, 3);
        pulse(M_INCP, 1);
        pulse(M_INCV, 2);
        adc_start(16, word);
        adc_finish();
        check("read3_word", word, 16'h0083);
        check("read3_sample_count", sample_count, 1);
        check("read3_protocol_error", protocol_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
